// File: rtl/core_pkg.sv
// Shared core definitions: load encodings, bus field offsets and default widths.
// Imported by the memory stage and by the load alignment helper.
package core_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LH   = 3'b010,
    LD_LW   = 3'b011,
    LD_LBU  = 3'b100,
    LD_LHU  = 3'b101
  } load_inst_e;

  // exe -> mem bus, LSB offsets of each field
  localparam int EX_LOAD_DATA_LSB = 0;
  localparam int EX_RSTRB_LSB     = 32;
  localparam int EX_ALU_LSB       = 36;
  localparam int EX_REGADDR_LSB   = 68;
  localparam int EX_REGW_BIT      = 73;
  localparam int EX_LOAD_INST_LSB = 74;
  localparam int EX_BUS_W         = 2*DATA_WIDTH + ADDR_WIDTH + 8;

  // mem -> wb bus (and forwarding bus, same layout)
  localparam int WB_RESULT_LSB  = 0;
  localparam int WB_REGADDR_LSB = 32;
  localparam int WB_REGW_BIT    = 37;
  localparam int WB_BUS_W       = DATA_WIDTH + ADDR_WIDTH + 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic is_load(input logic [2:0] li);
    return (li == LD_LB) || (li == LD_LH) || (li == LD_LW) ||
           (li == LD_LBU) || (li == LD_LHU);
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane selection and sign/zero extension of AXI-positioned read data.
// A load with no read strobes is flagged misaligned and yields zero.
module load_align
  import core_pkg::*;
(
  input  logic [2:0]  load_inst,
  input  logic [1:0]  off,
  input  logic [3:0]  rstrb,
  input  logic [31:0] load_data,
  output logic [31:0] result,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = load_data >> {off, 3'b000};
    result   = '0;
    misalign = 1'b0;
    if (is_load(load_inst) && (rstrb == 4'b0000)) begin
      misalign = 1'b1;
    end else begin
      case (load_inst)
        LD_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
        LD_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
        LD_LW:   result = load_data;
        LD_LBU:  result = {24'd0, shifted[7:0]};
        LD_LHU:  result = {16'd0, shifted[15:0]};
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: aligns load data, then holds the result in a
// single registered valid/ready slot feeding writeback and the forwarding bus.
module mem_stage
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [2*DATA_WIDTH+ADDR_WIDTH+7:0]  exe_to_mem_bus,
  input  logic                                exe_to_mem_valid,
  output logic                                mem_to_exe_ready,
  output logic [DATA_WIDTH+ADDR_WIDTH:0]      mem_to_wb_bus,
  output logic                                mem_to_wb_valid,
  input  logic                                wb_to_mem_ready,
  output logic [DATA_WIDTH+ADDR_WIDTH:0]      mem_fwd_bus,
  output logic                                mem_misalign
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. Ready depends only on slot occupancy and downstream ready, never on valid.

  logic [2:0]            in_load_inst;
  logic                  in_regw;
  logic [ADDR_WIDTH-1:0] in_regaddr;
  logic [DATA_WIDTH-1:0] in_alu;
  logic [3:0]            in_rstrb;
  logic [DATA_WIDTH-1:0] in_load_data;

  assign in_load_inst = exe_to_mem_bus[EX_LOAD_INST_LSB +: 3];
  assign in_regw      = exe_to_mem_bus[EX_REGW_BIT];
  assign in_regaddr   = exe_to_mem_bus[EX_REGADDR_LSB +: ADDR_WIDTH];
  assign in_alu       = exe_to_mem_bus[EX_ALU_LSB +: DATA_WIDTH];
  assign in_rstrb     = exe_to_mem_bus[EX_RSTRB_LSB +: 4];
  assign in_load_data = exe_to_mem_bus[EX_LOAD_DATA_LSB +: DATA_WIDTH];

  logic [DATA_WIDTH-1:0] align_result;
  logic                  align_misalign;

  load_align u_load_align (
    .load_inst (in_load_inst),
    .off       (in_alu[1:0]),
    .rstrb     (in_rstrb),
    .load_data (in_load_data),
    .result    (align_result),
    .misalign  (align_misalign)
  );

  logic [DATA_WIDTH-1:0] new_result;
  logic                  new_regw;

  assign new_result = is_load(in_load_inst) ? align_result : in_alu;
  // x0 is never a write target, and a misaligned load never writes.
  assign new_regw   = in_regw & (in_regaddr != '0) & ~align_misalign;

  slot_state_e           state_q, state_d;
  logic                  regw_q, regw_d;
  logic [ADDR_WIDTH-1:0] regaddr_q, regaddr_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  fwd_we_q, fwd_we_d;
  logic                  accept;

  assign mem_to_exe_ready = (state_q == SLOT_EMPTY) | wb_to_mem_ready;
  assign accept           = exe_to_mem_valid & mem_to_exe_ready;

  always_comb begin
    state_d   = state_q;
    regw_d    = regw_q;
    regaddr_d = regaddr_q;
    result_d  = result_q;
    fwd_we_d  = fwd_we_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (!accept && wb_to_mem_ready) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
    if (accept) begin
      regw_d    = new_regw;
      regaddr_d = in_regaddr;
      result_d  = new_result;
      fwd_we_d  = new_regw;
    end else if (wb_to_mem_ready) begin
      // Payload stays for observation; only the forward write-enable must drop.
      fwd_we_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SLOT_EMPTY;
      regw_q    <= 1'b0;
      regaddr_q <= '0;
      result_q  <= '0;
      fwd_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      regw_q    <= regw_d;
      regaddr_q <= regaddr_d;
      result_q  <= result_d;
      fwd_we_q  <= fwd_we_d;
    end
  end

  assign mem_to_wb_valid = (state_q == SLOT_FULL);
  assign mem_to_wb_bus   = {regw_q, regaddr_q, result_q};
  assign mem_fwd_bus     = {fwd_we_q, regaddr_q, result_q};
  assign mem_misalign    = accept & align_misalign & rst;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: spec-level result model, scoreboard queue of
// expected slot contents, per-cycle compare process and literal-pinned vectors.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [76:0] exe_to_mem_bus;
  logic        exe_to_mem_valid;
  logic        mem_to_exe_ready;
  logic [37:0] mem_to_wb_bus;
  logic        mem_to_wb_valid;
  logic        wb_to_mem_ready;
  logic [37:0] mem_fwd_bus;
  logic        mem_misalign;

  int checks = 0;
  int errors = 0;
  int n_pop  = 0;
  logic [37:0] exp_q[$];

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .exe_to_mem_valid (exe_to_mem_valid),
    .mem_to_exe_ready (mem_to_exe_ready),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .wb_to_mem_ready  (wb_to_mem_ready),
    .mem_fwd_bus      (mem_fwd_bus),
    .mem_misalign     (mem_misalign)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model of what the slot must hold for a given input bus.
  function automatic logic [37:0] model_out(input logic [76:0] b);
    logic [2:0]  li;
    logic        w;
    logic [4:0]  ra;
    logic [31:0] alu, ld, sh, res;
    logic [3:0]  sb;
    byte         b8;
    shortint     h16;
    li = b[76:74]; w = b[73]; ra = b[72:68]; alu = b[67:36]; sb = b[35:32]; ld = b[31:0];
    res = alu;
    if (li >= 3'd1 && li <= 3'd5) begin
      sh  = ld >> (8 * int'(alu[1:0]));
      b8  = sh[7:0];
      h16 = sh[15:0];
      if (sb == 4'd0) begin
        res = 32'd0;
        w   = 1'b0;
      end else if (li == 3'd1) res = 32'(int'(b8));
      else if (li == 3'd2) res = 32'(int'(h16));
      else if (li == 3'd3) res = ld;
      else if (li == 3'd4) res = 32'(sh[7:0]);
      else res = 32'(sh[15:0]);
    end
    if (ra == 5'd0) w = 1'b0;
    return {w, ra, res};
  endfunction

  // scoreboard / per-cycle compare
  always @(negedge clk) begin
    logic exp_valid, exp_ready, acc, mis_exp;
    logic [2:0] li;
    if (!rst) begin
      chk("rst_wb_valid", 38'(mem_to_wb_valid), 38'd0);
      chk("rst_wb_bus", mem_to_wb_bus, 38'd0);
      chk("rst_fwd_bus", mem_fwd_bus, 38'd0);
      chk("rst_ready", 38'(mem_to_exe_ready), 38'd1);
      chk("rst_misalign", 38'(mem_misalign), 38'd0);
    end else begin
      exp_valid = (exp_q.size() != 0);
      exp_ready = !exp_valid || wb_to_mem_ready;
      chk("wb_valid", 38'(mem_to_wb_valid), 38'(exp_valid));
      chk("ready", 38'(mem_to_exe_ready), 38'(exp_ready));
      if (exp_valid) begin
        chk("wb_bus", mem_to_wb_bus, exp_q[0]);
        chk("fwd_bus", mem_fwd_bus, exp_q[0]);
      end else begin
        chk("fwd_we_idle", 38'(mem_fwd_bus[37]), 38'd0);
      end
      acc = exe_to_mem_valid && exp_ready;
      li = exe_to_mem_bus[76:74];
      mis_exp = acc && (li >= 3'd1 && li <= 3'd5) && (exe_to_mem_bus[35:32] == 4'd0);
      chk("misalign", 38'(mem_misalign), 38'(mis_exp));
      if (exp_valid && wb_to_mem_ready) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (acc) exp_q.push_back(model_out(exe_to_mem_bus));
    end
  end

  // driver tasks
  logic last_mis;

  task automatic send(input logic [2:0] li, input logic rw, input logic [4:0] ra,
                      input logic [31:0] alu, input logic [3:0] sb, input logic [31:0] ld);
    int n;
    exe_to_mem_bus   = {li, rw, ra, alu, sb, ld};
    exe_to_mem_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (mem_to_exe_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 38'(mem_to_exe_ready), 38'd1);
        break;
      end
    end
    last_mis = mem_misalign;
    @(posedge clk); #1;
    exe_to_mem_valid = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [31:0] er, input logic ew, input logic em);
    @(negedge clk);
    chk({name, "_result"}, 38'(mem_to_wb_bus[31:0]), 38'(er));
    chk({name, "_regw"}, 38'(mem_to_wb_bus[37]), 38'(ew));
    chk({name, "_fwd_we"}, 38'(mem_fwd_bus[37]), 38'(ew));
    chk({name, "_misalign"}, 38'(last_mis), 38'(em));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  li;
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] alu;
    logic [3:0]  sb;
    logic [31:0] ld;
    logic [31:0] er;
    logic        ew;
    logic        em;
  } vec_t;

  vec_t vecs[$];
  logic [76:0] stream[4];
  logic [3:0]  wb_pat;

  initial begin
    int k, pop0, cyc;
    logic acc;
    rst = 1'b0;
    exe_to_mem_valid = 1'b0;
    exe_to_mem_bus = '0;
    wb_to_mem_ready = 1'b1;
    last_mis = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // directed vectors, expected values computed by hand
    vecs.push_back('{3'd4, 1'b1, 5'd5,  32'h8000_0003, 4'b1000, 32'hAB00_0000, 32'h0000_00AB, 1'b1, 1'b0});
    vecs.push_back('{3'd1, 1'b1, 5'd6,  32'h8000_0003, 4'b1000, 32'hAB00_0000, 32'hFFFF_FFAB, 1'b1, 1'b0});
    vecs.push_back('{3'd2, 1'b1, 5'd7,  32'h8000_0002, 4'b1100, 32'h8001_0000, 32'hFFFF_8001, 1'b1, 1'b0});
    vecs.push_back('{3'd2, 1'b1, 5'd8,  32'h8000_0003, 4'b0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{3'd0, 1'b1, 5'd0,  32'h0000_1234, 4'b0000, 32'h0000_0000, 32'h0000_1234, 1'b0, 1'b0});
    vecs.push_back('{3'd5, 1'b1, 5'd9,  32'h8000_0002, 4'b1100, 32'h8001_0000, 32'h0000_8001, 1'b1, 1'b0});
    vecs.push_back('{3'd3, 1'b1, 5'd10, 32'h8000_0001, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0});
    vecs.push_back('{3'd6, 1'b1, 5'd11, 32'h0000_0777, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0777, 1'b1, 1'b0});
    vecs.push_back('{3'd4, 1'b1, 5'd12, 32'h1000_0001, 4'b0010, 32'h0000_7F00, 32'h0000_007F, 1'b1, 1'b0});
    vecs.push_back('{3'd1, 1'b1, 5'd0,  32'h0000_0000, 4'b0001, 32'h0000_0080, 32'hFFFF_FF80, 1'b0, 1'b0});

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      send(vecs[i].li, vecs[i].rw, vecs[i].ra, vecs[i].alu, vecs[i].sb, vecs[i].ld);
      check_out($sformatf("vec%0d", i), vecs[i].er, vecs[i].ew, vecs[i].em);
    end

    // stream of four with downstream ready toggling 1,0,0,1
    stream[0] = {3'd0, 1'b1, 5'd1, 32'h0000_0011, 4'b0000, 32'h0};
    stream[1] = {3'd4, 1'b1, 5'd2, 32'h0000_0001, 4'b0010, 32'h0000_C300};
    stream[2] = {3'd0, 1'b1, 5'd3, 32'h0000_0033, 4'b0000, 32'h0};
    stream[3] = {3'd2, 1'b1, 5'd4, 32'h0000_0000, 4'b0011, 32'h0000_FFFE};
    wb_pat = 4'b1001;
    pop0 = n_pop;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      wb_to_mem_ready = wb_pat[cyc % 4];
      exe_to_mem_valid = 1'b1;
      exe_to_mem_bus = stream[k];
      @(negedge clk);
      acc = mem_to_exe_ready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    chk("stream_all_sent", 38'(k), 38'd4);
    exe_to_mem_valid = 1'b0;
    wb_to_mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stream_pops", 38'(n_pop - pop0), 38'd4);
    chk("stream_q_empty", 38'(exp_q.size()), 38'd0);

    // reset asserted while FULL and stalled
    wb_to_mem_ready = 1'b0;
    send(3'd0, 1'b1, 5'd7, 32'h0000_0055, 4'b0000, 32'h0);
    @(posedge clk); #3;
    chk("pre_rst_valid", 38'(mem_to_wb_valid), 38'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 38'(mem_to_wb_valid), 38'd0);
    chk("async_rst_fwd", mem_fwd_bus, 38'd0);
    chk("async_rst_bus", mem_to_wb_bus, 38'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 38'(mem_to_exe_ready), 38'd1);
    @(posedge clk); #1;
    wb_to_mem_ready = 1'b1;
    send(3'd4, 1'b1, 5'd3, 32'h0000_0002, 4'b0100, 32'h0055_0000);
    check_out("post_rst", 32'h0000_0055, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and the writeback stage. It accepts the execute stage's result bus, which carries the raw AXI read data for loads. For loads it selects the addressed byte or halfword lane and sign- or zero-extends it; for all other instructions it passes the ALU result through. The result is held in a registered valid/ready pipeline slot, which feeds writeback and also drives a forwarding bus back to decode.

## Interface
- ADDR_WIDTH, 5, register-address width
- DATA_WIDTH, 32, datapath width; the lane logic is defined for 32 only
- clk  in  1  rising-edge clock
- rst  in  1  reset, active-low, asynchronous assert; the only clock is clk
- exe_to_mem_bus  in  2*DATA_WIDTH+ADDR_WIDTH+8  fields, MSB→LSB:
  - load_inst[2:0] @[76:74]
  - d_regW @[73]
  - d_regAddr[4:0] @[72:68]
  - aluResult[31:0] @[67:36]
  - rstrb[3:0] @[35:32]
  - load_data[31:0] @[31:0]
- exe_to_mem_valid  in  1  bus valid
- mem_to_exe_ready  out  1  stage can accept
- mem_to_wb_bus  out  DATA_WIDTH+ADDR_WIDTH+1  {regW, regAddr, result}, 38 bits
- mem_to_wb_valid  out  1  output slot valid
- wb_to_mem_ready  in  1  writeback accepts
- mem_fwd_bus  out  DATA_WIDTH+ADDR_WIDTH+1  {fwd_we, regAddr, result}, where fwd_we = valid & regW
- mem_misalign  out  1  one-cycle pulse when an accepted load has rstrb==0

## Operation
- load_inst encoding:
  - 000 not a load
  - 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu
  - 110 and 111 are treated as 000
- Input lanes are AXI-positioned. off = aluResult[1:0]; shifted = load_data >> (8*off).
- Load result:
  - lb: sext(shifted[7:0]); lbu: zext(shifted[7:0])
  - lh: sext(shifted[15:0]); lhu: zext(shifted[15:0])
  - lw: load_data, off ignored
- Non-load result: aluResult.
- Misaligned load (load with rstrb==0, e.g. lh at off 3): result is 0, regW is forced to 0, and mem_misalign pulses in the accept cycle. The instruction still flows down the pipe.
- regW is forced to 0 when d_regAddr==0, so neither writeback nor forwarding ever sees x0 as a write.
- The result is computed combinationally from the input bus and captured in the output register on accept. All outputs except mem_to_exe_ready and mem_misalign come straight from flops.
- Slot control:
  - accept = exe_to_mem_valid & mem_to_exe_ready
  - mem_to_exe_ready = ~valid_q | wb_to_mem_ready
  - on accept: valid_q <= 1 and the payload is loaded
  - else if wb_to_mem_ready: valid_q <= 0
- States: EMPTY (valid_q=0) and FULL (valid_q=1).
  - EMPTY→FULL on accept
  - FULL→FULL on accept with wb ready (payload replaced) or while stalled (payload held)
  - FULL→EMPTY on wb ready with no accept

## Timing
- Reset (async, rst=0): valid_q=0 and payload=0, so mem_to_wb_valid=0, mem_to_wb_bus=0, mem_fwd_bus=0 and mem_misalign=0. mem_to_exe_ready=1 after reset.
- Latency is 1 cycle: data accepted at edge N appears at the outputs after edge N.
- Throughput is 1 per cycle while wb_to_mem_ready=1.
- While stalled (FULL and wb_to_mem_ready=0): mem_to_exe_ready=0; payload and fwd bus are stable; the input bus is ignored.
- Simultaneous drain and accept in the same cycle: no bubble; the new payload replaces the old one.
- Reset asserted mid-stall: the slot empties immediately. The in-flight instruction is lost, and this is acceptable because the whole core resets.
- mem_to_exe_ready has a combinational path from wb_to_mem_ready. There is no path from exe_to_mem_valid to mem_to_exe_ready.

## Structure
- Shared package (core_pkg):
  - load_inst encodings: LD_NONE, LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU
  - exe→mem and mem→wb bus field offsets
  - DATA_WIDTH and ADDR_WIDTH defaults
- One sub-module, load_align: purely combinational, inputs {load_inst, off, rstrb, load_data}, outputs {result, misalign}. It is reused later by the cache refill path.
- The top level holds the slot register and the handshake logic.

## Test plan
- lbu, addr 0x8000_0003, rdata 0xAB00_0000, rstrb 4'b1000 → result 0x0000_00AB one cycle later; fwd_we=1.
- lb, same address and data → result 0xFFFF_FFAB. lh, off 2, rdata 0x8001_0000 → 0xFFFF_8001.
- lh, off 3, rstrb 0 → mem_misalign pulses 1 cycle; wb bus regW=0, result 0.
- Non-load (load_inst 000), regAddr 0, aluResult 0x1234 → wb bus regW=0 and result 0x1234.
- Back-to-back stream of 4 instructions with wb_to_mem_ready toggling 1,0,0,1 → no loss or duplication; mem_to_exe_ready low exactly during the stalled cycles; payload stable while stalled.
- Assert rst mid-stall with FULL → mem_to_wb_valid drops without waiting for a clock edge; ready=1 after release.
